// File: rtl/axi_mm_pkg.sv
// Shared widths, link-word width functions and field offsets for the AXI4 MM master packer.
package axi_mm_pkg;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    typedef int unsigned fld_off_t;

    // AR/AW field offsets measured from the first bit above the id field
    localparam fld_off_t AX_SIZE_OFF  = 0;
    localparam fld_off_t AX_LEN_OFF   = SIZE_W;
    localparam fld_off_t AX_BURST_OFF = SIZE_W + LEN_W;
    localparam fld_off_t AX_ADDR_OFF  = SIZE_W + LEN_W + BURST_W;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

    function automatic int ar_w(input int id_w, input int addr_w);
        return id_w + int'(AX_ADDR_OFF) + addr_w;
    endfunction

    function automatic int w_w(input int id_w, input int data_w);
        return id_w + data_w + data_w / 8 + 1;
    endfunction

    function automatic int r_w(input int id_w, input int data_w);
        return id_w + data_w + 1 + RESP_W;
    endfunction

    function automatic int b_w(input int id_w);
        return id_w + RESP_W;
    endfunction

endpackage

// File: rtl/axi_mm_skid.sv
// Two-entry registered skid buffer: in-order, valid/ready on both sides, all outputs from flops.
module axi_mm_skid
    import axi_mm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_reg, state_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic [WIDTH-1:0] spare_reg, spare_next;
    logic             ready_reg, valid_reg;
    logic             push, pop;

    assign push      = in_valid & ready_reg;
    assign pop       = valid_reg & out_ready;
    assign in_ready  = ready_reg;
    assign out_valid = valid_reg;
    assign out_data  = head_reg;

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        spare_next = spare_reg;
        unique case (state_reg)
            SKID_EMPTY: begin
                if (push) begin
                    state_next = SKID_ONE;
                    head_next  = in_data;
                end
            end
            SKID_ONE: begin
                if (push && pop) begin
                    head_next = in_data;
                end else if (push) begin
                    state_next = SKID_FULL;
                    spare_next = in_data;
                end else if (pop) begin
                    state_next = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (pop) begin
                    state_next = SKID_ONE;
                    head_next  = spare_reg;
                end
            end
            default: state_next = SKID_EMPTY;
        endcase
    end

    // ready/valid are registered copies of the next-state decode so no comb path crosses the buffer
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= SKID_EMPTY;
            ready_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next != SKID_FULL);
            valid_reg <= (state_next != SKID_EMPTY);
        end
        head_reg  <= head_next;
        spare_reg <= spare_next;
    end

endmodule

// File: rtl/axi_mm_master_pack.sv
// AXI4 MM master-side packer: AR/AW/W packed into link words, R/B unpacked, one skid per channel.
// Define AXI_MM_MASTER_OST_LIMIT_EN to build the outstanding-burst limiter and its counters.
module axi_mm_master_pack
    import axi_mm_pkg::*;
#(
    parameter int  ID_W    = 2,
    parameter int  ADDR_W  = 32,
    parameter int  DATA_W  = 32,
    parameter int  MAX_OST = 8,
    localparam int STRB_W  = DATA_W / 8,
    localparam int AR_W    = ar_w(ID_W, ADDR_W),
    localparam int W_W     = w_w(ID_W, DATA_W),
    localparam int R_W     = r_w(ID_W, DATA_W),
    localparam int B_W     = b_w(ID_W),
    localparam int CNT_W   = $clog2(MAX_OST + 1)
) (
    input  logic                clk_wr,
    input  logic                rst_wr,
    input  logic [ID_W-1:0]     user_arid,
    input  logic [SIZE_W-1:0]   user_arsize,
    input  logic [LEN_W-1:0]    user_arlen,
    input  logic [BURST_W-1:0]  user_arburst,
    input  logic [ADDR_W-1:0]   user_araddr,
    input  logic                user_arvalid,
    output logic                user_arready,
    input  logic [ID_W-1:0]     user_awid,
    input  logic [SIZE_W-1:0]   user_awsize,
    input  logic [LEN_W-1:0]    user_awlen,
    input  logic [BURST_W-1:0]  user_awburst,
    input  logic [ADDR_W-1:0]   user_awaddr,
    input  logic                user_awvalid,
    output logic                user_awready,
    input  logic [ID_W-1:0]     user_wid,
    input  logic [DATA_W-1:0]   user_wdata,
    input  logic [STRB_W-1:0]   user_wstrb,
    input  logic                user_wlast,
    input  logic                user_wvalid,
    output logic                user_wready,
    output logic [ID_W-1:0]     user_rid,
    output logic [DATA_W-1:0]   user_rdata,
    output logic                user_rlast,
    output logic [RESP_W-1:0]   user_rresp,
    output logic                user_rvalid,
    input  logic                user_rready,
    output logic [ID_W-1:0]     user_bid,
    output logic [RESP_W-1:0]   user_bresp,
    output logic                user_bvalid,
    input  logic                user_bready,
    output logic                user_ar_vld,
    output logic [AR_W-1:0]     txfifo_ar_data,
    input  logic                user_ar_ready,
    output logic                user_aw_vld,
    output logic [AR_W-1:0]     txfifo_aw_data,
    input  logic                user_aw_ready,
    output logic                user_w_vld,
    output logic [W_W-1:0]      txfifo_w_data,
    input  logic                user_w_ready,
    input  logic                user_r_vld,
    input  logic [R_W-1:0]      rxfifo_r_data,
    output logic                user_r_ready,
    input  logic                user_b_vld,
    input  logic [B_W-1:0]      rxfifo_b_data,
    output logic                user_b_ready,
    output logic [CNT_W-1:0]    rd_ost_cnt,
    output logic [CNT_W-1:0]    wr_ost_cnt,
    output logic                ost_err
);

    // Address channels are handled as a pair: index 0 = read (AR), index 1 = write (AW)
    logic [1:0]                 ax_valid, ax_ready, ax_skid_ready;
    logic [1:0]                 ax_link_vld, ax_link_ready, ax_err;
    logic [1:0][ID_W-1:0]       ax_id;
    logic [1:0][SIZE_W-1:0]     ax_size;
    logic [1:0][LEN_W-1:0]      ax_len;
    logic [1:0][BURST_W-1:0]    ax_burst;
    logic [1:0][ADDR_W-1:0]     ax_addr;
    logic [1:0][AR_W-1:0]       ax_link_data;
    logic [1:0][CNT_W-1:0]      ax_cnt;

    assign ax_valid      = {user_awvalid, user_arvalid};
    assign ax_id         = {user_awid, user_arid};
    assign ax_size       = {user_awsize, user_arsize};
    assign ax_len        = {user_awlen, user_arlen};
    assign ax_burst      = {user_awburst, user_arburst};
    assign ax_addr       = {user_awaddr, user_araddr};
    assign ax_link_ready = {user_aw_ready, user_ar_ready};

    assign {user_awready, user_arready}     = ax_ready;
    assign {user_aw_vld, user_ar_vld}       = ax_link_vld;
    assign {txfifo_aw_data, txfifo_ar_data} = ax_link_data;
    assign rd_ost_cnt = ax_cnt[0];
    assign wr_ost_cnt = ax_cnt[1];
    assign ost_err    = |ax_err;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ax
        logic [AR_W-1:0] word;

        assign word[ID_W-1:0]                           = ax_id[gi];
        assign word[ID_W + AX_SIZE_OFF  +: SIZE_W]      = ax_size[gi];
        assign word[ID_W + AX_LEN_OFF   +: LEN_W]       = ax_len[gi];
        assign word[ID_W + AX_BURST_OFF +: BURST_W]     = ax_burst[gi];
        assign word[ID_W + AX_ADDR_OFF  +: ADDR_W]      = ax_addr[gi];

        axi_mm_skid #(.WIDTH(AR_W)) u_skid (
            .clk       (clk_wr),
            .srst      (rst_wr),
            .in_valid  (ax_valid[gi]),
            .in_ready  (ax_skid_ready[gi]),
            .in_data   (word),
            .out_valid (ax_link_vld[gi]),
            .out_ready (ax_link_ready[gi]),
            .out_data  (ax_link_data[gi])
        );

`ifdef AXI_MM_MASTER_OST_LIMIT_EN
        logic             inc, dec;
        logic [CNT_W-1:0] cnt_reg;
        logic             err_reg;

        // a read burst retires on its last R beat, a write burst on its B response
        assign dec = (gi == 0) ? (user_rvalid & user_rready & user_rlast)
                               : (user_bvalid & user_bready);
        assign inc = ax_valid[gi] & ax_ready[gi];
        assign ax_ready[gi] = ax_skid_ready[gi] & (cnt_reg < CNT_W'(MAX_OST));

        always_ff @(posedge clk_wr) begin
            if (rst_wr) begin
                cnt_reg <= '0;
                err_reg <= 1'b0;
            end else if (inc && !dec) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (dec && !inc) begin
                if (cnt_reg == '0)
                    err_reg <= 1'b1;
                else
                    cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end

        assign ax_cnt[gi] = cnt_reg;
        assign ax_err[gi] = err_reg;
`else
        assign ax_ready[gi] = ax_skid_ready[gi];
        assign ax_cnt[gi]   = '0;
        assign ax_err[gi]   = 1'b0;
`endif
    end

    axi_mm_skid #(.WIDTH(W_W)) u_w_skid (
        .clk       (clk_wr),
        .srst      (rst_wr),
        .in_valid  (user_wvalid),
        .in_ready  (user_wready),
        .in_data   ({user_wlast, user_wstrb, user_wdata, user_wid}),
        .out_valid (user_w_vld),
        .out_ready (user_w_ready),
        .out_data  (txfifo_w_data)
    );

    logic [R_W-1:0] r_word;
    logic [B_W-1:0] b_word;

    axi_mm_skid #(.WIDTH(R_W)) u_r_skid (
        .clk       (clk_wr),
        .srst      (rst_wr),
        .in_valid  (user_r_vld),
        .in_ready  (user_r_ready),
        .in_data   (rxfifo_r_data),
        .out_valid (user_rvalid),
        .out_ready (user_rready),
        .out_data  (r_word)
    );

    assign user_rid   = r_word[ID_W-1:0];
    assign user_rdata = r_word[ID_W +: DATA_W];
    assign user_rlast = r_word[ID_W + DATA_W];
    assign user_rresp = r_word[ID_W + DATA_W + 1 +: RESP_W];

    axi_mm_skid #(.WIDTH(B_W)) u_b_skid (
        .clk       (clk_wr),
        .srst      (rst_wr),
        .in_valid  (user_b_vld),
        .in_ready  (user_b_ready),
        .in_data   (rxfifo_b_data),
        .out_valid (user_bvalid),
        .out_ready (user_bready),
        .out_data  (b_word)
    );

    assign user_bid   = b_word[ID_W-1:0];
    assign user_bresp = b_word[ID_W +: RESP_W];

endmodule

// File: tb/tb_axi_mm_master_pack.sv
// Scoreboard bench for axi_mm_master_pack with ID_W=4, DATA_W=128, MAX_OST=2.
`timescale 1ns/1ps
module tb_axi_mm_master_pack;

    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 128;
    localparam int STRB_W  = 16;
    localparam int MAX_OST = 2;
    localparam int AR_W    = ID_W + 13 + ADDR_W;
    localparam int W_W     = ID_W + DATA_W + STRB_W + 1;
    localparam int R_W     = ID_W + DATA_W + 3;
    localparam int B_W     = ID_W + 2;
    localparam int CNT_W   = 2;
`ifdef AXI_MM_MASTER_OST_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic clk_wr = 1'b0;
    logic rst_wr;
    logic [ID_W-1:0] user_arid, user_awid, user_wid, user_rid, user_bid;
    logic [2:0] user_arsize, user_awsize;
    logic [7:0] user_arlen, user_awlen;
    logic [1:0] user_arburst, user_awburst, user_rresp, user_bresp;
    logic [ADDR_W-1:0] user_araddr, user_awaddr;
    logic user_arvalid, user_arready, user_awvalid, user_awready;
    logic [DATA_W-1:0] user_wdata, user_rdata;
    logic [STRB_W-1:0] user_wstrb;
    logic user_wlast, user_wvalid, user_wready;
    logic user_rlast, user_rvalid, user_rready, user_bvalid, user_bready;
    logic user_ar_vld, user_ar_ready, user_aw_vld, user_aw_ready, user_w_vld, user_w_ready;
    logic [AR_W-1:0] txfifo_ar_data, txfifo_aw_data;
    logic [W_W-1:0] txfifo_w_data;
    logic user_r_vld, user_r_ready, user_b_vld, user_b_ready;
    logic [R_W-1:0] rxfifo_r_data;
    logic [B_W-1:0] rxfifo_b_data;
    logic [CNT_W-1:0] rd_ost_cnt, wr_ost_cnt;
    logic ost_err;

    axi_mm_master_pack #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OST(MAX_OST)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr),
        .user_arid(user_arid), .user_arsize(user_arsize), .user_arlen(user_arlen),
        .user_arburst(user_arburst), .user_araddr(user_araddr),
        .user_arvalid(user_arvalid), .user_arready(user_arready),
        .user_awid(user_awid), .user_awsize(user_awsize), .user_awlen(user_awlen),
        .user_awburst(user_awburst), .user_awaddr(user_awaddr),
        .user_awvalid(user_awvalid), .user_awready(user_awready),
        .user_wid(user_wid), .user_wdata(user_wdata), .user_wstrb(user_wstrb),
        .user_wlast(user_wlast), .user_wvalid(user_wvalid), .user_wready(user_wready),
        .user_rid(user_rid), .user_rdata(user_rdata), .user_rlast(user_rlast),
        .user_rresp(user_rresp), .user_rvalid(user_rvalid), .user_rready(user_rready),
        .user_bid(user_bid), .user_bresp(user_bresp), .user_bvalid(user_bvalid),
        .user_bready(user_bready),
        .user_ar_vld(user_ar_vld), .txfifo_ar_data(txfifo_ar_data), .user_ar_ready(user_ar_ready),
        .user_aw_vld(user_aw_vld), .txfifo_aw_data(txfifo_aw_data), .user_aw_ready(user_aw_ready),
        .user_w_vld(user_w_vld), .txfifo_w_data(txfifo_w_data), .user_w_ready(user_w_ready),
        .user_r_vld(user_r_vld), .rxfifo_r_data(rxfifo_r_data), .user_r_ready(user_r_ready),
        .user_b_vld(user_b_vld), .rxfifo_b_data(rxfifo_b_data), .user_b_ready(user_b_ready),
        .rd_ost_cnt(rd_ost_cnt), .wr_ost_cnt(wr_ost_cnt), .ost_err(ost_err)
    );

    always #5 clk_wr = ~clk_wr;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic              last;
        logic [1:0]        resp;
    } r_exp_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    int checks = 0;
    int errors = 0;
    logic [AR_W-1:0] ar_q[$];
    logic [AR_W-1:0] aw_q[$];
    logic [W_W-1:0]  w_q[$];
    r_exp_t          r_q[$];
    b_exp_t          b_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [255:0] act);
        checks++;
        errors++;
        $display("FAIL %s act=%0h exp=none t=%0t", name, act, $time);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk_wr) begin
        if (!rst_wr && user_ar_vld === 1'b1 && user_ar_ready) begin
            if (ar_q.size() == 0) flag("ar_extra", 256'(txfifo_ar_data));
            else begin
                chk("ar_word", 256'(txfifo_ar_data), 256'(ar_q.pop_front()));
                $display("TXN ar link word=%0h", txfifo_ar_data);
            end
        end
        if (!rst_wr && user_aw_vld === 1'b1 && user_aw_ready) begin
            if (aw_q.size() == 0) flag("aw_extra", 256'(txfifo_aw_data));
            else begin
                chk("aw_word", 256'(txfifo_aw_data), 256'(aw_q.pop_front()));
                $display("TXN aw link word=%0h", txfifo_aw_data);
            end
        end
        if (!rst_wr && user_w_vld === 1'b1 && user_w_ready) begin
            if (w_q.size() == 0) flag("w_extra", 256'(txfifo_w_data));
            else begin
                chk("w_word", 256'(txfifo_w_data), 256'(w_q.pop_front()));
                $display("TXN w link word=%0h", txfifo_w_data);
            end
        end
    end

    always @(negedge clk_wr) begin
        r_exp_t re;
        b_exp_t be;
        if (!rst_wr && user_rvalid === 1'b1 && user_rready) begin
            if (r_q.size() == 0) flag("r_extra", 256'(user_rdata));
            else begin
                re = r_q.pop_front();
                chk("r_id", 256'(user_rid), 256'(re.id));
                chk("r_data", 256'(user_rdata), 256'(re.data));
                chk("r_last", 256'(user_rlast), 256'(re.last));
                chk("r_resp", 256'(user_rresp), 256'(re.resp));
                $display("TXN r id=%0h data=%0h last=%0b resp=%0d", user_rid, user_rdata, user_rlast, user_rresp);
            end
        end
        if (!rst_wr && user_bvalid === 1'b1 && user_bready) begin
            if (b_q.size() == 0) flag("b_extra", 256'(user_bid));
            else begin
                be = b_q.pop_front();
                chk("b_id", 256'(user_bid), 256'(be.id));
                chk("b_resp", 256'(user_bresp), 256'(be.resp));
                $display("TXN b id=%0h resp=%0d", user_bid, user_bresp);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_ax(input bit wr, input logic [ID_W-1:0] id, input logic [2:0] size,
                           input logic [7:0] len, input logic [1:0] burst, input logic [ADDR_W-1:0] addr);
        bit done = 0;
        int n = 0;
        if (wr) begin
            user_awid = id; user_awsize = size; user_awlen = len; user_awburst = burst;
            user_awaddr = addr; user_awvalid = 1'b1;
        end else begin
            user_arid = id; user_arsize = size; user_arlen = len; user_arburst = burst;
            user_araddr = addr; user_arvalid = 1'b1;
        end
        while (!done) begin
            @(negedge clk_wr);
            if ((wr ? user_awready : user_arready) === 1'b1) begin
                if (wr) aw_q.push_back({addr, burst, len, size, id});
                else    ar_q.push_back({addr, burst, len, size, id});
                done = 1;
            end else if (n++ >= 50) begin
                flag(wr ? "aw_timeout" : "ar_timeout", 256'(addr));
                done = 1;
            end
            @(posedge clk_wr); #1;
        end
        if (wr) user_awvalid = 1'b0;
        else    user_arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data,
                          input logic [STRB_W-1:0] strb, input logic last);
        bit done = 0;
        int n = 0;
        user_wid = id; user_wdata = data; user_wstrb = strb; user_wlast = last; user_wvalid = 1'b1;
        while (!done) begin
            @(negedge clk_wr);
            if (user_wready === 1'b1) begin
                w_q.push_back({last, strb, data, id});
                done = 1;
            end else if (n++ >= 50) begin
                flag("w_timeout", 256'(data));
                done = 1;
            end
            @(posedge clk_wr); #1;
        end
        user_wvalid = 1'b0;
    endtask

    task automatic send_r(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data,
                          input logic last, input logic [1:0] resp);
        bit done = 0;
        int n = 0;
        rxfifo_r_data = {resp, last, data, id};
        user_r_vld = 1'b1;
        while (!done) begin
            @(negedge clk_wr);
            if (user_r_ready === 1'b1) begin
                r_q.push_back('{id: id, data: data, last: last, resp: resp});
                done = 1;
            end else if (n++ >= 50) begin
                flag("r_timeout", 256'(data));
                done = 1;
            end
            @(posedge clk_wr); #1;
        end
        user_r_vld = 1'b0;
    endtask

    task automatic send_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
        bit done = 0;
        int n = 0;
        rxfifo_b_data = {resp, id};
        user_b_vld = 1'b1;
        while (!done) begin
            @(negedge clk_wr);
            if (user_b_ready === 1'b1) begin
                b_q.push_back('{id: id, resp: resp});
                done = 1;
            end else if (n++ >= 50) begin
                flag("b_timeout", 256'(id));
                done = 1;
            end
            @(posedge clk_wr); #1;
        end
        user_b_vld = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [DATA_W-1:0] d0, d1, d2, rd0, rd1;
        int n;
        d0  = 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f;
        d1  = 128'hdead_beef_cafe_f00d_1234_5678_9abc_def0;
        d2  = 128'hffff_0000_aaaa_5555_f0f0_0f0f_3c3c_c3c3;
        rd0 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
        rd1 = 128'h7654_3210_fedc_ba98_0011_2233_4455_6677;

        rst_wr = 1'b1;
        user_arvalid = 0; user_awvalid = 0; user_wvalid = 0;
        user_arid = '0; user_arsize = '0; user_arlen = '0; user_arburst = '0; user_araddr = '0;
        user_awid = '0; user_awsize = '0; user_awlen = '0; user_awburst = '0; user_awaddr = '0;
        user_wid = '0; user_wdata = '0; user_wstrb = '0; user_wlast = 0;
        user_rready = 1; user_bready = 1;
        user_ar_ready = 1; user_aw_ready = 1; user_w_ready = 1;
        user_r_vld = 0; rxfifo_r_data = '0; user_b_vld = 0; rxfifo_b_data = '0;

        repeat (3) @(posedge clk_wr);
        @(negedge clk_wr);
        chk("rst_arready", 256'(user_arready), 256'(0));
        chk("rst_wready", 256'(user_wready), 256'(0));
        chk("rst_r_ready", 256'(user_r_ready), 256'(0));
        chk("rst_ar_vld", 256'(user_ar_vld), 256'(0));
        chk("rst_rvalid", 256'(user_rvalid), 256'(0));
        chk("rst_rd_cnt", 256'(rd_ost_cnt), 256'(0));
        chk("rst_err", 256'(ost_err), 256'(0));

        @(posedge clk_wr); #1 rst_wr = 1'b0;
        @(posedge clk_wr);
        @(negedge clk_wr);
        chk("rel_arready", 256'(user_arready), 256'(1));
        chk("rel_awready", 256'(user_awready), 256'(1));
        chk("rel_wready", 256'(user_wready), 256'(1));
        chk("rel_r_ready", 256'(user_r_ready), 256'(1));
        chk("rel_b_ready", 256'(user_b_ready), 256'(1));
        @(posedge clk_wr); #1;

        // single AR, one-cycle latency, count 1
        send_ax(0, 4'd1, 3'd2, 8'd3, 2'b01, 32'h0000_1000);
        @(negedge clk_wr);
        chk("ar_lat", 256'(user_ar_vld), 256'(1));
        chk("rd_cnt_1", 256'(rd_ost_cnt), 256'(LIM ? 1 : 0));
        @(posedge clk_wr); #1;

        // R field positions with rlast=0 (no retire)
        send_r(4'hA, rd0, 1'b0, 2'b10);

        // W backpressure: two accepted, then stall, then back-to-back drain
        user_w_ready = 0;
        fork
            begin
                send_w(4'h3, d0, 16'hffff, 1'b0);
                send_w(4'h3, d1, 16'h00ff, 1'b0);
                send_w(4'h3, d2, 16'h8001, 1'b1);
            end
            begin
                repeat (4) @(negedge clk_wr);
                chk("w_stall", 256'(user_wready), 256'(0));
                repeat (2) @(posedge clk_wr);
                #1 user_w_ready = 1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk_wr);
                    chk("w_b2b", 256'(user_w_vld), 256'(1));
                end
            end
        join
        @(posedge clk_wr); #1;

        // outstanding limit: second AR fills, third stalls until an rlast returns
        send_ax(0, 4'd2, 3'd4, 8'd0, 2'b01, 32'h0000_2000);
        @(negedge clk_wr);
        chk("rd_cnt_2", 256'(rd_ost_cnt), 256'(LIM ? 2 : 0));
        @(posedge clk_wr); #1;
        fork
            send_ax(0, 4'd3, 3'd4, 8'd7, 2'b10, 32'h0000_3000);
            begin
                repeat (4) @(negedge clk_wr);
                chk("ar_stall", 256'(user_arready), 256'(LIM ? 0 : 1));
                @(posedge clk_wr); #1;
                send_r(4'h5, rd1, 1'b1, 2'b01);
            end
        join
        @(negedge clk_wr);
        chk("rd_cnt_3", 256'(rd_ost_cnt), 256'(LIM ? 2 : 0));
        @(posedge clk_wr); #1;

        // same-cycle AW handshake and B handshake at wr count 1
        send_ax(1, 4'd4, 3'd2, 8'd0, 2'b01, 32'h0000_4000);
        @(negedge clk_wr);
        chk("wr_cnt_1", 256'(wr_ost_cnt), 256'(LIM ? 1 : 0));
        @(posedge clk_wr); #1;
        user_bready = 0;
        send_b(4'd4, 2'b00);
        user_bready = 1;
        user_awid = 4'd5; user_awsize = 3'd3; user_awlen = 8'd15; user_awburst = 2'b01;
        user_awaddr = 32'h0000_5000; user_awvalid = 1;
        @(negedge clk_wr);
        chk("same_bvalid", 256'(user_bvalid), 256'(1));
        chk("same_awready", 256'(user_awready), 256'(1));
        if (user_awready === 1'b1) aw_q.push_back({32'h0000_5000, 2'b01, 8'd15, 3'd3, 4'd5});
        @(posedge clk_wr); #1 user_awvalid = 0;
        @(negedge clk_wr);
        chk("wr_cnt_same", 256'(wr_ost_cnt), 256'(LIM ? 1 : 0));
        @(posedge clk_wr); #1;

        // retire the last write, then a B with nothing outstanding
        send_b(4'd5, 2'b01);
        @(posedge clk_wr); #1;
        @(negedge clk_wr);
        chk("wr_cnt_0", 256'(wr_ost_cnt), 256'(0));
        chk("err_clear", 256'(ost_err), 256'(0));
        @(posedge clk_wr); #1;
        send_b(4'd6, 2'b11);
        @(posedge clk_wr); #1;
        @(negedge clk_wr);
        chk("err_set", 256'(ost_err), 256'(LIM ? 1 : 0));
        chk("wr_cnt_floor", 256'(wr_ost_cnt), 256'(0));
        repeat (3) @(posedge clk_wr);
        @(negedge clk_wr);
        chk("err_sticky", 256'(ost_err), 256'(LIM ? 1 : 0));
        @(posedge clk_wr); #1;

        // reset with R beats parked in the skid
        user_rready = 0;
        send_r(4'h1, d0, 1'b0, 2'b00);
        send_r(4'h2, d1, 1'b0, 2'b00);
        r_q.delete();
        rst_wr = 1'b1;
        @(posedge clk_wr); #1;
        @(negedge clk_wr);
        chk("mid_rvalid", 256'(user_rvalid), 256'(0));
        chk("mid_ar_vld", 256'(user_ar_vld), 256'(0));
        chk("mid_w_vld", 256'(user_w_vld), 256'(0));
        chk("mid_rd_cnt", 256'(rd_ost_cnt), 256'(0));
        chk("mid_wr_cnt", 256'(wr_ost_cnt), 256'(0));
        chk("mid_err", 256'(ost_err), 256'(0));
        @(posedge clk_wr); #1 rst_wr = 1'b0; user_rready = 1;
        @(posedge clk_wr); #1;
        send_ax(0, 4'd7, 3'd2, 8'd1, 2'b01, 32'h0000_7000);
        @(negedge clk_wr);
        chk("post_rd_cnt", 256'(rd_ost_cnt), 256'(LIM ? 1 : 0));

        n = 0;
        while ((ar_q.size() + aw_q.size() + w_q.size() + r_q.size() + b_q.size()) != 0 && n < 20) begin
            @(negedge clk_wr);
            n++;
        end
        chk("ar_left", 256'(ar_q.size()), 256'(0));
        chk("aw_left", 256'(aw_q.size()), 256'(0));
        chk("w_left", 256'(w_q.size()), 256'(0));
        chk("r_left", 256'(r_q.size()), 256'(0));
        chk("b_left", 256'(b_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
